// File: rtl/upload_arbiter.sv
// Round-robin merge of handler upload bursts into framed USB upload packets:
// header, source ID, 16-bit length, payload, 8-bit additive checksum.
module upload_arbiter #(
  parameter int          NUM_SOURCES = 4,
  parameter int          MAX_PKT_LEN = 256,
  parameter logic [15:0] FRAME_HDR   = 16'hAA44
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SOURCES-1:0]   src_upload_req,
  input  logic [8*NUM_SOURCES-1:0] src_upload_data,
  input  logic [8*NUM_SOURCES-1:0] src_upload_source,
  input  logic [NUM_SOURCES-1:0]   src_upload_valid,
  output logic [NUM_SOURCES-1:0]   src_upload_ready,
  output logic [7:0]               usb_upload_data,
  output logic                     usb_upload_valid,
  input  logic                     usb_upload_ready,
  output logic                     busy
);

  localparam int          GW      = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;
  localparam int          AW      = (MAX_PKT_LEN > 1) ? $clog2(MAX_PKT_LEN) : 1;
  localparam logic [15:0] MAX_LEN = 16'(MAX_PKT_LEN);

  typedef enum logic [3:0] {
    IDLE, COLLECT, HDR0, HDR1, SID, LENH, LENL, DATA, CKSUM
  } state_t;

  state_t          state;
  logic [GW-1:0]   grant, last_grant, pick, cand;
  logic            found;
  logic [15:0]     count, rd_idx, rd_next;
  logic [7:0]      cksum, sid, out_byte;
  logic            out_valid;
  logic [7:0]      in_byte, in_sid;
  logic            in_req, in_valid, collect_open, in_xfer, out_xfer;
  logic [AW-1:0]   buf_addr;
  logic [7:0]      buf_rd_p1;
  logic [7:0]      mem [MAX_PKT_LEN];

  function automatic logic [7:0] frame_sum(input logic [7:0] s, input logic [15:0] len,
                                           input logic [7:0] payload_sum);
    return s + len[15:8] + len[7:0] + payload_sum;
  endfunction

  // Cyclic scan starting just after the previous winner
  always_comb begin
    found = 1'b0;
    pick  = last_grant;
    cand  = '0;
    for (int k = 1; k <= NUM_SOURCES; k++) begin
      cand = GW'((int'(last_grant) + k) % NUM_SOURCES);
      if (!found && src_upload_req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    in_byte  = '0;
    in_sid   = '0;
    in_req   = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (grant == GW'(i)) begin
        in_byte  = src_upload_data[8*i +: 8];
        in_sid   = src_upload_source[8*i +: 8];
        in_req   = src_upload_req[i];
        in_valid = src_upload_valid[i];
      end
    end
  end

  assign collect_open = (state == COLLECT) && (count < MAX_LEN);
  assign in_xfer      = collect_open && in_valid;
  assign out_xfer     = out_valid && usb_upload_ready;
  assign rd_next      = rd_idx + 16'd1;

  always_comb begin
    src_upload_ready = '0;
    for (int i = 0; i < NUM_SOURCES; i++)
      src_upload_ready[i] = collect_open && (grant == GW'(i));
  end

  // Reads run one byte ahead during DATA so the registered read port never stalls the stream
  assign buf_addr = (state == COLLECT) ? count[AW-1:0] :
                    (state == DATA && out_xfer) ? rd_next[AW-1:0] : rd_idx[AW-1:0];

  always_ff @(posedge clk) begin
    if (in_xfer) mem[buf_addr] <= in_byte;
    buf_rd_p1 <= mem[buf_addr];
  end

  assign usb_upload_data  = (state == DATA) ? buf_rd_p1 : out_byte;
  assign usb_upload_valid = out_valid;
  assign busy             = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_SOURCES - 1);
      count      <= '0;
      cksum      <= '0;
      sid        <= '0;
      rd_idx     <= '0;
      out_byte   <= '0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (found) begin
          grant      <= pick;
          last_grant <= pick;
          count      <= '0;
          cksum      <= '0;
          rd_idx     <= '0;
          state      <= COLLECT;
        end
        COLLECT: begin
          if (in_xfer) begin
            if (count == 16'd0) sid <= in_sid;
            count <= count + 16'd1;
            cksum <= cksum + in_byte;
          end
          if (count == MAX_LEN || (!in_req && !in_xfer)) begin
            if (count == 16'd0) begin
              state <= IDLE;
            end else begin
              state     <= HDR0;
              out_valid <= 1'b1;
              out_byte  <= FRAME_HDR[15:8];
            end
          end
        end
        HDR0: if (out_xfer) begin out_byte <= FRAME_HDR[7:0]; state <= HDR1; end
        HDR1: if (out_xfer) begin out_byte <= sid;            state <= SID;  end
        SID:  if (out_xfer) begin out_byte <= count[15:8];    state <= LENH; end
        LENH: if (out_xfer) begin out_byte <= count[7:0];     state <= LENL; end
        LENL: if (out_xfer) state <= DATA;
        DATA: if (out_xfer) begin
          if (rd_next == count) begin
            out_byte <= frame_sum(sid, count, cksum);
            state    <= CKSUM;
          end else begin
            rd_idx <= rd_next;
          end
        end
        CKSUM: if (out_xfer) begin out_valid <= 1'b0; state <= IDLE; end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_upload_arbiter.sv
// Bench for upload_arbiter: directed scenarios plus randomized rounds checked
// against a queue-based frame model.
`timescale 1ns/1ps
module tb_upload_arbiter;
  localparam int          N   = 4;
  localparam int          MAX = 4;
  localparam logic [15:0] HDR = 16'hAA44;

  typedef logic [7:0] bq_t[$];
  typedef struct packed { logic [7:0] b; logic last; } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0]   req, valid, ready, hs;
  logic [8*N-1:0] data, source;
  logic [7:0]     usb_data;
  logic           usb_valid, usb_ready, busy;

  always #5 clk = ~clk;

  upload_arbiter #(.NUM_SOURCES(N), .MAX_PKT_LEN(MAX), .FRAME_HDR(HDR)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_upload_req(req), .src_upload_data(data), .src_upload_source(source),
    .src_upload_valid(valid), .src_upload_ready(ready),
    .usb_upload_data(usb_data), .usb_upload_valid(usb_valid),
    .usb_upload_ready(usb_ready), .busy(busy)
  );

  exp_t       exp_q[$];
  logic [7:0] src_q [N][$];
  bit         pulse [N];
  logic [7:0] sid_tab [N] = '{8'h10, 8'h01, 8'h22, 8'h33};
  int         ready_mode = 0;
  int         passed = 0, total = 0, out_cnt = 0;
  int         model_last = N - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act === want) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, want);
  endtask

  function automatic void hex_to_q(input logic [255:0] v, input int n, output bq_t q);
    q.delete();
    for (int k = 0; k < n; k++) q.push_back(v[8*(n-1-k) +: 8]);
  endfunction

  // Frame model: header, id, length MSB first, payload, 8-bit sum of id/length/payload
  function automatic void frame_bytes(input logic [7:0] s, input bq_t pl, output bq_t f);
    logic [15:0] len;
    logic [7:0]  sum;
    len = 16'(pl.size());
    f.delete();
    f.push_back(HDR[15:8]); f.push_back(HDR[7:0]); f.push_back(s);
    f.push_back(len[15:8]); f.push_back(len[7:0]);
    sum = s + len[15:8] + len[7:0];
    foreach (pl[k]) begin f.push_back(pl[k]); sum = sum + pl[k]; end
    f.push_back(sum);
  endfunction

  task automatic expect_q(input bq_t f);
    foreach (f[k]) exp_q.push_back('{b: f[k], last: (k == f.size() - 1)});
  endtask

  task automatic expect_hex(input logic [255:0] v, input int n);
    bq_t f;
    hex_to_q(v, n, f);
    expect_q(f);
  endtask

  task automatic send(input int s, input logic [255:0] v, input int n);
    bq_t q;
    hex_to_q(v, n, q);
    foreach (q[k]) src_q[s].push_back(q[k]);
  endtask

  function automatic bit sources_pending();
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Randomized round: all masked sources request together; model derives frame order
  task automatic run_round(input logic [N-1:0] mask);
    logic [7:0] rem [N][$];
    bq_t pl, f;
    int left, g;
    logic [7:0] b;
    left = 0;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        int n = $urandom_range(1, 10);
        for (int k = 0; k < n; k++) begin
          b = 8'($urandom);
          rem[i].push_back(b);
          src_q[i].push_back(b);
        end
        left += n;
      end
    end
    while (left > 0) begin
      g = model_last;
      do g = (g + 1) % N; while (rem[g].size() == 0);
      pl.delete();
      while (pl.size() < MAX && rem[g].size() > 0) begin
        pl.push_back(rem[g].pop_front());
        left--;
      end
      frame_bytes(sid_tab[g], pl, f);
      expect_q(f);
      model_last = g;
    end
  endtask

  task automatic wait_drain(input string name);
    int cyc = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0 || sources_pending()) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_valid"}, usb_valid, 0);
    exp_q.delete();
    for (int i = 0; i < N; i++) src_q[i].delete();
  endtask

  task automatic wait_out(input int target);
    int cyc = 0;
    while (out_cnt < target && cyc < 2000) begin @(negedge clk); cyc++; end
    check("wait_out_bound", (out_cnt >= target), 1);
  endtask

  // Source and sink driver
  initial begin
    req = '0; valid = '0; data = '0; usb_ready = 1'b1;
    for (int i = 0; i < N; i++) source[8*i +: 8] = sid_tab[i];
    forever begin
      @(negedge clk);
      hs = valid & ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        req[i]   = (src_q[i].size() > 0) || pulse[i];
        valid[i] = (src_q[i].size() > 0) && ($urandom_range(3) != 0);
        data[8*i +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
      end
      case (ready_mode)
        0:       usb_ready = 1'b1;
        1:       usb_ready = ~usb_ready;
        default: usb_ready = ($urandom_range(1) == 1);
      endcase
    end
  end

  // Output monitor
  logic       pv = 0, pr = 0, plast = 1, pxfer = 0;
  logic [7:0] pd = 0;
  exp_t       e;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 0; pxfer = 0;
      end else begin
        check("ready_onehot", ($countones(ready) <= 1), 1);
        if (usb_valid) check("ready_while_sending", ready, 0);
        if (pv && !pr) begin
          check("hold_valid", usb_valid, 1);
          check("hold_data", usb_data, pd);
        end
        if (pxfer && !plast) check("no_gap", usb_valid, 1);
        pxfer = 0;
        if (usb_valid && usb_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_byte: got %02h expected none", usb_data);
          end else begin
            e = exp_q.pop_front();
            check("out_byte", usb_data, e.b);
            plast = e.last;
            pxfer = 1;
            out_cnt++;
          end
        end
        pv = usb_valid; pr = usb_ready; pd = usb_data;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bq_t f, lit, pl;
    int start;
    for (int i = 0; i < N; i++) pulse[i] = 0;

    // Model pinned against hand-computed frames
    hex_to_q(256'h112233, 3, pl);
    frame_bytes(8'h01, pl, f);
    hex_to_q(256'hAA44010003112233_6A, 9, lit);
    check("model_len", f.size(), 9);
    foreach (lit[k]) check("model_pin", f[k], lit[k]);
    hex_to_q(256'h01020304, 4, pl);
    frame_bytes(8'h10, pl, f);
    check("model_trunc_sum", f[f.size()-1], 8'h1E);

    rst_n = 1'b0;
    #1;
    check("rst_valid", usb_valid, 0);
    check("rst_data", usb_data, 0);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single source
    expect_hex(256'hAA44010003112233_6A, 9);
    send(1, 256'h112233, 3);
    wait_drain("single");

    // Empty request pulse from source 3
    @(negedge clk);
    pulse[3] = 1;
    repeat (2) @(posedge clk);
    #2;
    pulse[3] = 0;
    repeat (8) @(negedge clk);
    wait_drain("empty");

    // Round-robin: 0 before 2, then late 3 before late 0
    start = out_cnt;
    expect_hex(256'hAA4410_0002_A1A2_55, 8);
    expect_hex(256'hAA4422_0002_B1B2_87, 8);
    expect_hex(256'hAA4433_0002_C1C2_B8, 8);
    expect_hex(256'hAA4410_0002_D1D2_B5, 8);
    send(0, 256'hA1A2, 2);
    send(2, 256'hB1B2, 2);
    wait_out(start + 10);
    send(3, 256'hC1C2, 2);
    send(0, 256'hD1D2, 2);
    wait_drain("rr");

    // Output backpressure
    ready_mode = 1;
    expect_hex(256'hAA44010003112233_6A, 9);
    send(1, 256'h112233, 3);
    wait_drain("backpressure");
    ready_mode = 0;

    // Truncation at MAX bytes
    expect_hex(256'hAA4410_0004_01020304_1E, 10);
    expect_hex(256'hAA4410_0002_0506_1D, 8);
    send(0, 256'h010203040506, 6);
    wait_drain("trunc");

    // Mid-frame reset
    start = out_cnt;
    expect_hex(256'hAA44010003112233_6A, 9);
    send(1, 256'h112233, 3);
    wait_out(start + 6);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < N; i++) src_q[i].delete();
    #1;
    check("midrst_valid", usb_valid, 0);
    check("midrst_ready", ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_data", usb_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_last = N - 1;
    @(negedge clk);
    run_round(4'b0011);
    wait_drain("after_reset");

    // Randomized rounds
    for (int r = 0; r < 40; r++) begin
      ready_mode = $urandom_range(2);
      run_round(4'($urandom_range(1, 15)));
      wait_drain("random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
